// File: rtl/ldpc_iter_ctrl.sv
// LDPC iteration controller: accepts one channel frame, loads it into the
// VNU array, runs decode iterations until the syndrome passes or the
// iteration limit is hit, then holds the decoded result until taken.
module ldpc_iter_ctrl #(
    parameter int N        = 64,
    parameter int MAX_ITER = 32,
    parameter int ITER_W   = 6,
    parameter int ITER_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_sig,
    output logic [N-1:0]      dec_llr,
    output logic              dec_load,
    output logic              dec_run,
    input  logic [N-1:0]      dec_bits,
    input  logic              syn_ok,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_res,
    output logic              out_err,
    output logic [ITER_W-1:0] out_iter
);

    localparam int CYC_W = $clog2(ITER_CYC) + 1;
    localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(ITER_CYC - 1);
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ITER_W-1:0] iter;
    logic [ITER_W-1:0] iter_inc;
    logic [CYC_W-1:0]  cyc;
    logic              accept;
    logic              iter_end;
    logic              capture;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; flush overrides every other event in the cycle
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        iter_end  = 1'b0;
        capture   = 1'b0;
        iter_inc  = iter + ITER_W'(1);
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (cyc == CYC_LAST) begin
                    iter_end = 1'b1;
                    if (syn_ok || (iter_inc == ITER_MAX)) begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (flush) begin
            state_nxt = IDLE;
            accept    = 1'b0;
            iter_end  = 1'b0;
            capture   = 1'b0;
        end
    end

    // Registered outputs (decoded from next state) plus frame and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            dec_load  <= 1'b0;
            dec_run   <= 1'b0;
            out_valid <= 1'b0;
            dec_llr   <= '0;
            out_res   <= '0;
            out_err   <= 1'b0;
            out_iter  <= '0;
            iter      <= '0;
            cyc       <= '0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            dec_load  <= (state_nxt == LOAD);
            dec_run   <= (state_nxt == RUN);
            out_valid <= (state_nxt == HOLD);
            if (accept) begin
                dec_llr <= in_sig;
            end
            if (state == LOAD) begin
                iter <= '0;
                cyc  <= '0;
            end else if (state == RUN) begin
                cyc <= (cyc == CYC_LAST) ? '0 : cyc + CYC_W'(1);
            end
            if (iter_end) begin
                iter <= iter_inc;
            end
            // syn_ok wins over the limit: a pass on the last iteration is not an error
            if (capture) begin
                out_res  <= dec_bits;
                out_err  <= ~syn_ok;
                out_iter <= iter_inc;
            end
        end
    end

endmodule
